// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with writeback bypass and per-register busy scoreboard
// Two combinational read ports, one writeback port, issue-time destination reservation.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rdy1,
  output logic             rdy2,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             busy_err,
  output logic [AW:0]      pending_count
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             busy_err_q, busy_err_d;
  logic [AW:0]      pending_count_q, pending_count_d;

  logic wb_live, issue_live;

  assign wb_live    = wb_en && (wb_addr != '0);
  assign issue_live = issue_en && (issue_addr != '0);

  // Issue is applied after writeback so a same-cycle new producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_live) busy_d[wb_addr] = 1'b0;
    if (issue_live) busy_d[issue_addr] = 1'b1;

    busy_err_d = issue_live && busy_q[issue_addr] && !(wb_live && (wb_addr == issue_addr));

    pending_count_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending_count_d = pending_count_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q          <= '0;
      busy_err_q      <= 1'b0;
      pending_count_q <= '0;
    end else begin
      if (wb_live) regs_q[wb_addr] <= wb_data;
      busy_q          <= busy_d;
      busy_err_q      <= busy_err_d;
      pending_count_q <= pending_count_d;
    end
  end

  // Read ports: register 0 is constant zero, then writeback bypass, then storage.
  always_comb begin
    rd1  = '0;
    rdy1 = 1'b1;
    if (ra1 != '0) begin
      if (wb_en && (wb_addr == ra1)) begin
        rd1  = wb_data;
        rdy1 = 1'b1;
      end else begin
        rd1  = regs_q[ra1];
        rdy1 = ~busy_q[ra1];
      end
    end
  end

  always_comb begin
    rd2  = '0;
    rdy2 = 1'b1;
    if (ra2 != '0) begin
      if (wb_en && (wb_addr == ra2)) begin
        rd2  = wb_data;
        rdy2 = 1'b1;
      end else begin
        rd2  = regs_q[ra2];
        rdy2 = ~busy_q[ra2];
      end
    end
  end

  assign busy_err      = busy_err_q;
  assign pending_count = pending_count_q;

endmodule
